// File: rtl/serial_frame_ctrl_pkg.sv
// Shared definitions for the serial frame controller: state encoding and
// the default frame width.
package serial_frame_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_STOP  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out capture register. Each bit is its own reset flop
// with a private load enable, so the controller decides which bit position
// takes the serial input on a given edge. A synchronous clear wipes the
// whole word at the start of every frame.
module sipo_shift_reg
  import serial_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] load,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  // Per-bit load of the serial input, clear wins over any load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (load[i]) begin
          q[i] <= d;
        end
      end
    end
  end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Serial frame controller: detects a start bit on D, captures WIDTH data
// bits LSB-first into a SIPO register, checks the stop bit and offers the
// word on a VALID/READY handshake. Flags framing errors (one-cycle FERR)
// and overruns (sticky OVR, cleared by CLR).
module serial_frame_ctrl
  import serial_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_L,
  input  logic             EN,
  input  logic             D,
  input  logic             READY,
  input  logic             CLR,
  output logic [WIDTH-1:0] DOUT,
  output logic             VALID,
  output logic             FERR,
  output logic             OVR,
  output logic             BUSY
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] load_en;
  logic            sreg_clr;

  // Clear the capture register on the start bit and steer the serial bit
  // into position cnt while shifting; an abort edge loads nothing
  always_comb begin
    sreg_clr = (state == S_IDLE) && EN && D;
    load_en  = '0;
    if ((state == S_SHIFT) && EN) begin
      load_en = WIDTH'(1) << cnt;
    end
  end

  sipo_shift_reg #(
    .WIDTH (WIDTH)
  ) u_sreg (
    .clk   (CLK),
    .rst_n (RST_L),
    .clr   (sreg_clr),
    .load  (load_en),
    .d     (D),
    .q     (sreg)
  );

  // Frame sequencing, bit counter and registered status outputs
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state <= S_IDLE;
      cnt   <= '0;
      DOUT  <= '0;
      VALID <= 1'b0;
      FERR  <= 1'b0;
      OVR   <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      FERR <= 1'b0;
      if (CLR) begin
        OVR <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (EN && D) begin
            state <= S_SHIFT;
            cnt   <= '0;
            BUSY  <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (!EN) begin
            state <= S_IDLE;
            cnt   <= '0;
            BUSY  <= 1'b0;
          end else if (cnt == LAST_BIT) begin
            state <= S_STOP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          BUSY <= 1'b0;
          if (!EN) begin
            state <= S_IDLE;
          end else if (!D) begin
            state <= S_DONE;
            DOUT  <= sreg;
            VALID <= 1'b1;
          end else begin
            state <= S_IDLE;
            FERR  <= 1'b1;
          end
        end
        S_DONE: begin
          if (READY) begin
            state <= S_IDLE;
            VALID <= 1'b0;
          end else if (EN && D) begin
            OVR <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Self-checking bench for serial_frame_ctrl. Frames are built from data
// words; the expected outputs follow from the frame-level rules (a good
// stop bit publishes the word, a bad one pulses FERR and keeps the last
// word, a start bit while a word is pending sets OVR).
module tb_serial_frame_ctrl;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST_L;
  logic             EN;
  logic             D;
  logic             READY;
  logic             CLR;
  logic [WIDTH-1:0] DOUT;
  logic             VALID;
  logic             FERR;
  logic             OVR;
  logic             BUSY;

  int               checks   = 0;
  int               failures = 0;
  logic [WIDTH-1:0] exp_dout;
  logic [WIDTH-1:0] rand_word;
  logic             rand_stop;

  serial_frame_ctrl #(
    .WIDTH (WIDTH)
  ) dut (
    .CLK   (CLK),
    .RST_L (RST_L),
    .EN    (EN),
    .D     (D),
    .READY (READY),
    .CLR   (CLR),
    .DOUT  (DOUT),
    .VALID (VALID),
    .FERR  (FERR),
    .OVR   (OVR),
    .BUSY  (BUSY)
  );

  // Free-running clock, 10 time units per period
  always #5 CLK = ~CLK;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge, outputs are sampled on the next one
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive(input logic en, input logic d, input logic ready,
                       input logic clr);
    EN    = en;
    D     = d;
    READY = ready;
    CLR   = clr;
    tick();
  endtask

  // Send start bit, WIDTH data bits LSB-first and the given stop bit
  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic stop_bit);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("start_busy", 16'(BUSY), 16'd1);
    for (int i = 0; i < WIDTH; i++) begin
      drive(1'b1, data[i], 1'b0, 1'b0);
    end
    checkOutput("shift_busy", 16'(BUSY), 16'd1);
    checkOutput("shift_valid", 16'(VALID), 16'd0);
    drive(1'b1, stop_bit, 1'b0, 1'b0);
    checkOutput("stop_busy", 16'(BUSY), 16'd0);
    if (!stop_bit) begin
      exp_dout = data;
      checkOutput("good_valid", 16'(VALID), 16'd1);
      checkOutput("good_dout", 16'(DOUT), 16'(exp_dout));
      checkOutput("good_ferr", 16'(FERR), 16'd0);
    end else begin
      checkOutput("ferr_pulse", 16'(FERR), 16'd1);
      checkOutput("ferr_valid", 16'(VALID), 16'd0);
      checkOutput("ferr_dout", 16'(DOUT), 16'(exp_dout));
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("ferr_one_cycle", 16'(FERR), 16'd0);
    end
  endtask

  // Hold the word for wait_n cycles, then accept it
  task automatic do_handshake(input int wait_n);
    for (int i = 0; i < wait_n; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("hold_valid", 16'(VALID), 16'd1);
      checkOutput("hold_dout", 16'(DOUT), 16'(exp_dout));
      checkOutput("hold_ovr", 16'(OVR), 16'd0);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("hs_valid", 16'(VALID), 16'd0);
    checkOutput("hs_dout", 16'(DOUT), 16'(exp_dout));
  endtask

  // Directed sequence with randomized frame contents
  initial begin
    RST_L = 1'b0;
    EN    = 1'b0;
    D     = 1'b0;
    READY = 1'b0;
    CLR   = 1'b0;
    exp_dout = '0;
    #1;
    checkOutput("rst_dout", 16'(DOUT), 16'd0);
    checkOutput("rst_valid", 16'(VALID), 16'd0);
    checkOutput("rst_ferr", 16'(FERR), 16'd0);
    checkOutput("rst_ovr", 16'(OVR), 16'd0);
    checkOutput("rst_busy", 16'(BUSY), 16'd0);
    @(negedge CLK);
    RST_L = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_busy", 16'(BUSY), 16'd0);

    $display("[TB] good frame 0x4D");
    applyStimulus(8'h4D, 1'b0);
    checkOutput("dout_4d", 16'(DOUT), 16'h004D);
    do_handshake(2);

    $display("[TB] random frames");
    for (int f = 0; f < 10; f++) begin
      rand_word = WIDTH'($urandom);
      rand_stop = ($urandom_range(0, 3) == 0);
      applyStimulus(rand_word, rand_stop);
      if (!rand_stop) begin
        do_handshake(int'($urandom_range(0, 3)));
      end
    end

    $display("[TB] framing error");
    applyStimulus(~exp_dout, 1'b1);

    $display("[TB] abort then 0xA5");
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("abort_busy", 16'(BUSY), 16'd0);
    checkOutput("abort_ferr", 16'(FERR), 16'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_valid", 16'(VALID), 16'd0);
    applyStimulus(8'hA5, 1'b0);
    checkOutput("dout_a5", 16'(DOUT), 16'h00A5);

    $display("[TB] overrun and clear");
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("ovr_set", 16'(OVR), 16'd1);
    checkOutput("ovr_valid", 16'(VALID), 16'd1);
    checkOutput("ovr_dout", 16'(DOUT), 16'h00A5);
    checkOutput("ovr_busy", 16'(BUSY), 16'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("done_en_low_valid", 16'(VALID), 16'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_clr", 16'(OVR), 16'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("ovr_set_beats_clr", 16'(OVR), 16'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_clr2", 16'(OVR), 16'd0);

    $display("[TB] same-edge handshake and start bit");
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("same_edge_valid", 16'(VALID), 16'd0);
    checkOutput("same_edge_ovr", 16'(OVR), 16'd0);
    checkOutput("same_edge_busy", 16'(BUSY), 16'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("same_edge_no_frame", 16'(BUSY), 16'd0);

    $display("[TB] async reset mid-frame");
    rand_word = WIDTH'($urandom) | WIDTH'(1);
    applyStimulus(rand_word, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst_ovr", 16'(OVR), 16'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("ovr_sticky", 16'(OVR), 16'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom), 1'b0, 1'b0);
    end
    checkOutput("pre_rst_busy", 16'(BUSY), 16'd1);
    #2;
    RST_L = 1'b0;
    #1;
    checkOutput("async_dout", 16'(DOUT), 16'd0);
    checkOutput("async_valid", 16'(VALID), 16'd0);
    checkOutput("async_ferr", 16'(FERR), 16'd0);
    checkOutput("async_ovr", 16'(OVR), 16'd0);
    checkOutput("async_busy", 16'(BUSY), 16'd0);
    exp_dout = '0;
    EN = 1'b0;
    D  = 1'b0;
    @(negedge CLK);
    RST_L = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_busy", 16'(BUSY), 16'd0);
    rand_word = WIDTH'($urandom);
    applyStimulus(rand_word, 1'b0);
    do_handshake(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_frame_ctrl.md
Name: serial_frame_ctrl

Overview:
- Sequences a D-flip-flop-based serial-in/parallel-out capture path.
- Watches a one-bit serial line D, detects a start bit, and shifts WIDTH data bits LSB-first.
- Checks a stop bit, then presents the captured word on a valid/ready handshake.
- Sits between the single-bit D/flip-flop datapath from earlier experiments and any parallel consumer; flags framing errors and overruns.

Parameters:
- WIDTH, 8, number of data bits per frame (2..16).
- CW, $clog2(WIDTH), bit-counter width (derived; not overridden).

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST_L  input  1  asynchronous active-low reset; one clock, reset asynchronous, active-low.
- EN  input  1  capture enable; low aborts any frame in progress.
- D  input  1  serial data, sampled on each rising CLK edge.
- READY  input  1  consumer accepts DOUT when VALID & READY.
- CLR  input  1  synchronous clear of sticky OVR.
- DOUT  output  WIDTH  captured word, stable while VALID = 1.
- VALID  output  1  DOUT holds an unconsumed word.
- FERR  output  1  one-cycle pulse: stop bit was 1.
- OVR  output  1  sticky: start bit seen while a word was pending.
- BUSY  output  1  high in SHIFT or STOP.

Behaviour:
- Reset (RST_L = 0, immediate, no clock required): state = IDLE, cnt = 0, shift register = 0, DOUT = 0, VALID = 0, FERR = 0, OVR = 0, BUSY = 0.
- IDLE:
  - EN & D = 1 -> SHIFT, cnt <= 0.
  - Otherwise stay.
- SHIFT:
  - Each edge: sreg[cnt] <= D, cnt <= cnt + 1.
  - When cnt == WIDTH-1 (last bit sampled this edge) -> STOP.
  - EN = 0 -> IDLE immediately (next edge); partial data discarded, no FERR.
- STOP:
  - D = 0 -> DONE; DOUT <= sreg; VALID <= 1.
  - D = 1 -> IDLE; FERR high for exactly the following cycle; DOUT unchanged.
  - EN = 0 -> IDLE; no FERR.
- DONE:
  - VALID = 1; DOUT frozen.
  - VALID & READY on an edge -> IDLE; VALID low after that edge.
  - D = 1 & EN & !READY on an edge -> OVR <= 1; the frame is NOT captured.
  - EN is ignored for leaving DONE.
- Latency: start bit sampled at edge k -> data bits at edges k+1..k+WIDTH -> stop bit at edge k+WIDTH+1 -> VALID high after edge k+WIDTH+1. Minimum gap between frames: one IDLE cycle after the handshake.
- Same-edge precedence:
  - READY handshake and D = 1 on the same edge in DONE: handshake wins, no OVR; that D is not treated as a start bit.
  - CLR and an OVR set on the same edge: set wins.
- Width rules:
  - cnt never exceeds WIDTH-1.
  - sreg is cleared on entry to SHIFT, so aborted frames cannot leak bits.
- FERR never asserts outside the cycle after STOP.
- Reset mid-frame or mid-handshake returns all outputs to reset values asynchronously. Release is synchronised by the user; the first post-release edge may sample a start bit.

Decomposition:
- Shared package: state encoding constants S_IDLE = 2'd0, S_SHIFT = 2'd1, S_STOP = 2'd2, S_DONE = 2'd3, and the default WIDTH.
- One sub-module is natural: sipo_shift_reg (WIDTH-bit, per-bit load enable, synchronous clear, async active-low reset). It is built from the same reset-flop style as the single D flip-flop.
- FSM, counter and flags stay in the top block.

Test Plan:
- Reset async: assert RST_L = 0 mid-SHIFT at a non-edge time -> all outputs 0 within the same timestep, state IDLE.
- Good frame, WIDTH = 8: EN = 1, D sequence 1, then 1,0,1,1,0,0,1,0 (LSB first), then 0, READY = 0 -> VALID rises after edge 10, DOUT = 8'h4D held. Raise READY -> VALID low after the next edge.
- Framing error: same start and data, stop bit D = 1 -> FERR = 1 for exactly one cycle, VALID stays 0, DOUT keeps its previous value.
- Abort: drop EN after 3 data bits -> IDLE next edge, BUSY = 0. A following good frame 0xA5 yields DOUT = 8'hA5 with no stale bits.
- Overrun: hold READY = 0 in DONE, drive D = 1 -> OVR = 1, DOUT unchanged. CLR = 1 for one cycle -> OVR = 0. CLR coincident with a new set -> OVR stays 1.
- Same-edge handshake: READY = 1 and D = 1 on the same edge in DONE -> no OVR, state IDLE, no new frame started.
